// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register and its command sequencer.
// Command op values match the USR sel values, so the sequencer can pass an op straight to sel.
package usr_pkg;

    localparam logic [1:0] USR_HOLD = 2'b00;
    localparam logic [1:0] USR_SHR  = 2'b01;
    localparam logic [1:0] USR_SHL  = 2'b10;
    localparam logic [1:0] USR_LOAD = 2'b11;

    localparam logic [1:0] OP_READ  = USR_HOLD;
    localparam logic [1:0] OP_SHR   = USR_SHR;
    localparam logic [1:0] OP_SHL   = USR_SHL;
    localparam logic [1:0] OP_LOAD  = USR_LOAD;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        EXEC    = 2'b01,
        CAPTURE = 2'b10
    } state_t;

endpackage

// File: rtl/usr_shift_controller.sv
// Command sequencer for the 4-bit USR: drives sel/parin for exactly the required
// number of cycles, then captures the USR contents into result and pulses done.
module usr_shift_controller
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [1:0]       usr_sel,
    output logic [WIDTH-1:0] usr_parin,
    input  logic [WIDTH-1:0] usr_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output state_t           state
);

    logic [CNT_W-1:0] remaining;

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_op/cmd_data/cmd_count are sampled only on that edge. cmd_ready is high only
    // in IDLE with clr low, so nothing presented while busy has any effect.
    assign cmd_ready = (state == IDLE) && !clr;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            remaining <= '0;
            usr_sel   <= USR_HOLD;
            usr_parin <= '0;
            result    <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_LOAD: begin
                                usr_parin <= cmd_data;
                                usr_sel   <= USR_LOAD;
                                remaining <= CNT_W'(1);
                                state     <= EXEC;
                            end
                            OP_SHR, OP_SHL: begin
                                if (cmd_count != '0) begin
                                    usr_sel   <= cmd_op;
                                    remaining <= cmd_count;
                                    state     <= EXEC;
                                end else begin
                                    state <= CAPTURE;
                                end
                            end
                            default: state <= CAPTURE;
                        endcase
                    end
                end
                EXEC: begin
                    // sel stays fixed until the last step edge; the USR then holds for capture.
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        usr_sel <= USR_HOLD;
                        state   <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    result <= usr_out;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    usr_sel <= USR_HOLD;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usr_shift_controller.sv
// Bench for usr_shift_controller paired with a behavioural 4-bit USR register;
// expected results come from plain shift arithmetic on a tracked register value.
module tb_usr_shift_controller;
    import usr_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             clr;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic [1:0]       usr_sel;
    logic [WIDTH-1:0] usr_parin;
    logic [WIDTH-1:0] usr_out;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    state_t           state;

    int pass_cnt = 0;
    int total    = 0;
    int model_val = 0;
    logic [WIDTH-1:0] exp_q[$];

    usr_shift_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
        .usr_sel(usr_sel), .usr_parin(usr_parin), .usr_out(usr_out),
        .busy(busy), .done(done), .result(result), .state(state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // USR environment model: load, right/left with zero fill, hold, cleared by clr
    always_ff @(posedge clk or posedge clr) begin
        if (clr) usr_out <= '0;
        else begin
            case (usr_sel)
                2'b11: usr_out <= usr_parin;
                2'b01: usr_out <= usr_out >> 1;
                2'b10: usr_out <= usr_out << 1;
                default: usr_out <= usr_out;
            endcase
        end
    end

    // reference: value after command, register modelled as an integer 0..15
    function automatic int ref_value(input int cur, input logic [1:0] op, input int data, input int cnt);
        case (op)
            2'b11: return data;
            2'b01: return cur / (2 ** cnt);
            2'b10: return (cur * (2 ** cnt)) % 16;
            default: return cur;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input int cnt);
        if (op == 2'b11) return 2;
        if ((op == 2'b01 || op == 2'b10) && cnt != 0) return cnt + 1;
        return 1;
    endfunction

    function automatic int ref_active(input logic [1:0] op, input int cnt);
        if (op == 2'b11) return 1;
        if (op == 2'b01 || op == 2'b10) return cnt;
        return 0;
    endfunction

    // driver: issue one command, observe until done (bounded)
    task automatic send_cmd(input logic [1:0] op, input logic [3:0] data, input logic [2:0] cnt,
                            output logic [3:0] res, output int lat, output int active,
                            output logic [1:0] last_sel, output logic rdy_at_done);
        int guard;
        res = 'x; lat = -1; active = 0; last_sel = 2'b00; rdy_at_done = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_count = cnt;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        // busy-time garbage on the cmd bus must be ignored
        cmd_op = 2'($urandom_range(0, 3)); cmd_data = 4'($urandom); cmd_count = 3'($urandom);
        for (int e = 1; e <= 50; e++) begin
            if (usr_sel != 2'b00) begin
                active++;
                last_sel = usr_sel;
            end
            @(posedge clk);
            #1;
            if (done) begin
                lat = e;
                res = result;
                rdy_at_done = cmd_ready;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0; cmd_count = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({usr_sel, usr_parin, result, done, busy, cmd_ready} !== 14'b0) begin
            $display("FAIL reset_outputs: sel=%b parin=%b result=%b done=%b busy=%b ready=%b, required all zero",
                     usr_sel, usr_parin, result, done, busy, cmd_ready);
        end else pass_cnt++;
        @(negedge clk);
        clr = 1'b0;
        #1;
        total++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", cmd_ready);
        else pass_cnt++;
        model_val = 0;
    endtask

    task automatic test_load();
        logic [3:0] res; int lat, act; logic [1:0] ls; logic rdy;
        send_cmd(2'b11, 4'b1011, 3'd0, res, lat, act, ls, rdy);
        model_val = ref_value(model_val, 2'b11, 11, 0);
        total++;
        if (res !== 4'(model_val) || lat != 2)
            $display("FAIL load_result: result=%b lat=%0d required %b lat=2", res, lat, 4'(model_val));
        else pass_cnt++;
        total++;
        if (act != 1 || ls !== 2'b11)
            $display("FAIL load_sel: active=%0d sel=%b required 1 cycle of 11", act, ls);
        else pass_cnt++;
        total++;
        if (rdy !== 1'b1) $display("FAIL load_ready_with_done: got %b required 1", rdy);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0) $display("FAIL load_done_width: done=%b one cycle later, required 0", done);
        else pass_cnt++;
    endtask

    task automatic test_shift();
        logic [3:0] res; int lat, act; logic [1:0] ls; logic rdy;
        send_cmd(2'b01, 4'b0000, 3'd2, res, lat, act, ls, rdy);
        model_val = ref_value(model_val, 2'b01, 0, 2);
        total++;
        if (res !== 4'(model_val) || res !== 4'b0010 || lat != 3)
            $display("FAIL shr2: result=%b lat=%0d required 0010 lat=3", res, lat);
        else pass_cnt++;
        total++;
        if (act != 2 || ls !== 2'b01) $display("FAIL shr2_sel: active=%0d sel=%b required 2 of 01", act, ls);
        else pass_cnt++;
        send_cmd(2'b10, 4'b0000, 3'd3, res, lat, act, ls, rdy);
        model_val = ref_value(model_val, 2'b10, 0, 3);
        total++;
        if (res !== 4'(model_val) || lat != 4 || act != 3 || ls !== 2'b10)
            $display("FAIL shl3: result=%b lat=%0d active=%0d sel=%b required %b lat=4 active=3 sel=10",
                     res, lat, act, ls, 4'(model_val));
        else pass_cnt++;
    endtask

    task automatic test_zero_count();
        logic [3:0] res; int lat, act; logic [1:0] ls; logic rdy;
        send_cmd(2'b11, 4'b0110, 3'd0, res, lat, act, ls, rdy);
        model_val = 6;
        send_cmd(2'b10, 4'b1111, 3'd0, res, lat, act, ls, rdy);
        total++;
        if (res !== 4'b0110 || lat != 1 || act != 0)
            $display("FAIL shl0: result=%b lat=%0d active=%0d required 0110 lat=1 active=0", res, lat, act);
        else pass_cnt++;
        send_cmd(2'b00, 4'b1111, 3'd7, res, lat, act, ls, rdy);
        total++;
        if (res !== 4'b0110 || lat != 1 || act != 0)
            $display("FAIL read: result=%b lat=%0d active=%0d required 0110 lat=1 active=0", res, lat, act);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int e;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 4'b1011; cmd_count = '0;
        for (e = 0; e < 50; e++) begin
            @(posedge clk);
            #1;
            if (done) break;
        end
        total++;
        if (e >= 50) $display("FAIL b2b_first_done: no done within 50 cycles, required done");
        else pass_cnt++;
        total++;
        if (busy !== 1'b0 || result !== 4'b1011)
            $display("FAIL b2b_first_result: busy=%b result=%b required busy=0 result=1011", busy, result);
        else pass_cnt++;
        cmd_op = 2'b00;
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL b2b_accept_edge: busy=%b done=%b required busy=1 done=0", busy, done);
        else pass_cnt++;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b1 || result !== 4'b1011)
            $display("FAIL b2b_read: done=%b result=%b required done=1 result=1011", done, result);
        else pass_cnt++;
        model_val = 11;
    endtask

    task automatic test_clr_abort();
        logic [3:0] res; int lat, act; logic [1:0] ls; logic rdy; int seen_done;
        send_cmd(2'b11, 4'b1111, 3'd0, res, lat, act, ls, rdy);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_count = 3'd5; cmd_data = 4'b0000;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (usr_out !== 4'b0011 || usr_sel !== 2'b01)
            $display("FAIL clr_midshift_state: usr=%b sel=%b required 0011 sel=01", usr_out, usr_sel);
        else pass_cnt++;
        clr = 1'b1;
        #1;
        total++;
        if ({usr_sel, usr_parin, result, done, busy, cmd_ready} !== 14'b0)
            $display("FAIL clr_abort_outputs: sel=%b parin=%b result=%b done=%b busy=%b ready=%b, required all zero",
                     usr_sel, usr_parin, result, done, busy, cmd_ready);
        else pass_cnt++;
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 4'b0101;
        seen_done = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (seen_done != 0 || busy !== 1'b1 || usr_sel !== 2'b11)
            $display("FAIL clr_first_accept: dones=%0d busy=%b sel=%b required 0 dones busy=1 sel=11",
                     seen_done, busy, usr_sel);
        else pass_cnt++;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (done !== 1'b1 || result !== 4'b0101)
            $display("FAIL clr_reload: done=%b result=%b required done=1 result=0101", done, result);
        else pass_cnt++;
        model_val = 5;
    endtask

    task automatic test_random();
        logic [3:0] res; int lat, act; logic [1:0] ls; logic rdy;
        logic [1:0] op; logic [3:0] data; logic [2:0] cnt; logic [3:0] exp_v;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            data = 4'($urandom);
            cnt = 3'($urandom_range(0, 7));
            model_val = ref_value(model_val, op, int'(data), int'(cnt));
            exp_q.push_back(4'(model_val));
            send_cmd(op, data, cnt, res, lat, act, ls, rdy);
            exp_v = exp_q.pop_front();
            total++;
            if (res !== exp_v || lat != ref_latency(op, int'(cnt)) || act != ref_active(op, int'(cnt))
                || (act != 0 && ls !== op) || rdy !== 1'b1)
                $display("FAIL random_%0d op=%b cnt=%0d: result=%b lat=%0d active=%0d sel=%b ready=%b required %b lat=%0d active=%0d",
                         i, op, cnt, res, lat, act, ls, rdy, exp_v, ref_latency(op, int'(cnt)), ref_active(op, int'(cnt)));
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_shift();
        test_zero_count();
        test_back_to_back();
        test_clr_abort();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/usr_shift_controller.md
# usr_shift_controller

Command sequencer for the 4-bit universal shift register (USR). Accepts one command at a time over a valid/ready handshake: load, shift-right N, shift-left N, or read. Drives the USR `sel`/`parin` inputs for the exact number of cycles required, captures the USR `out` afterwards and pulses `done`. Sits between the control logic and the USR instance; the USR shares `clk` and `clr` with this block.

## Interface
- `WIDTH`, 4, USR data width
- `CNT_W`, 3, width of the shift-count field; max shifts per command is 2^CNT_W−1
- `clk` in 1: single clock, rising edge
- `clr` in 1: asynchronous, active-high reset
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: block can accept a command; equals (state==IDLE) && !clr
- `cmd_op` in 2: 00 read, 01 shift right, 10 shift left, 11 load
- `cmd_data` in WIDTH: load value, used only when op=11
- `cmd_count` in CNT_W: shift count, used only when op=01/10
- `usr_sel` out 2: to USR `sel`; 00 hold, 01 right, 10 left, 11 load
- `usr_parin` out WIDTH: to USR `parin`
- `usr_out` in WIDTH: from USR `out`
- `busy` out 1: state != IDLE
- `done` out 1: one-cycle pulse when `result` is updated
- `result` out WIDTH: USR contents captured at command end

## Operation
- States: IDLE, EXEC, CAPTURE.
- IDLE: `usr_sel`=00. The command is accepted on an edge where `cmd_valid && cmd_ready` holds.
  - op=11: `usr_parin`<=`cmd_data`, `usr_sel`<=11, remaining<=1, next state EXEC.
  - op=01/10 with count≠0: `usr_sel`<=op, remaining<=`cmd_count`, next state EXEC.
  - op=00, or shift with count=0: `usr_sel` stays 00, next state CAPTURE.
- EXEC: on each edge, remaining decrements.
  - When remaining==1 on an edge, `usr_sel`<=00 and the next state is CAPTURE.
  - `usr_sel` is constant for the whole EXEC phase.
- CAPTURE: on the edge, `result`<=`usr_out`, `done`<=1, next state IDLE.
- `done` is low in every other cycle.
- `usr_parin` changes only when a load is accepted; otherwise it holds its last value.
- Outputs `usr_sel`, `usr_parin`, `result` and `done` are registered, with no combinational path from the cmd inputs.
- `cmd_*` inputs are sampled only on the accept edge. Changes while busy are ignored.
- `clr` asserted, in any state or mid-shift:
  - immediately sets state=IDLE, `usr_sel`=00, `usr_parin`=0, `result`=0, `done`=0, `busy`=0, `cmd_ready`=0, remaining=0.
  - No `done` is produced for the aborted command.

## Timing
- Accept at edge k:
  - N-shift command: USR updates at edges k+1..k+N; `done`/`result` are valid after edge k+N+1.
  - Load: USR loads at k+1; `done` after k+2.
  - Read or count-0 command: `done` after k+1.
- `cmd_ready` is high in the cycle following `done`. The earliest next accept is edge k+N+2, so there is one idle edge minimum between commands.
- `done` and `cmd_ready` are simultaneously high for that one cycle.
- First accept after `clr` deasserts: the first rising edge with `clr` low and `cmd_valid` high.

## Structure
- Shared package `usr_pkg`:
  - sel encodings `USR_HOLD`=00, `USR_SHR`=01, `USR_SHL`=10, `USR_LOAD`=11;
  - op encodings (identical values);
  - state enum {IDLE, EXEC, CAPTURE}.
- No sub-module. The step down-counter and FSM stay inline. The USR is instantiated by the parent, not inside this block.

## Test plan
The bench pairs the block with a USR model: 11 load, 01 right with 0 fill, 10 left with 0 fill, 00 hold, cleared by `clr`.
- Reset: hold `clr`=1 for 3 cycles → `usr_sel`=00, `usr_parin`=0000, `result`=0000, `done`=0, `busy`=0, `cmd_ready`=0. Release `clr` → `cmd_ready`=1.
- Load 1011 accepted at edge k → `usr_sel`=11 for exactly one cycle, `done` pulse after k+2, `result`=1011.
- After the load, shift right with count=2 → `usr_sel`=01 for 2 cycles, `done` after k+3, `result`=0010. Then shift left with count=3 → `result`=0000.
- Shift left with count=0 on USR=0110 → `usr_sel` never leaves 00, `done` after k+1, `result`=0110.
- Hold `cmd_valid`=1 with load 1011, then read → second accept occurs exactly one edge after the first `done`, and the second `result`=1011.
- Load 1111, then shift right with count=5; assert `clr` after the 2nd shift edge → all outputs reset immediately, no `done` pulse, and the next load 0101 completes normally with `result`=0101.
